// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its issue queue:
// op encodings, datapath width and the queued command format.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [1:0]       op;
    logic             use_acc;
  } alu_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Generic DEPTH-entry synchronous FIFO with registered occupancy count.
// Pushes while full and pops while empty are ignored.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage for the 4-bit ALU: buffers commands, drives the head onto the
// ALU, and captures the result into an output slot plus an accumulator.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_use_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_out,
  input  logic         alu_equal,
  input  logic         alu_even,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_out,
  output logic         res_equal,
  output logic         res_even,
  output logic [W-1:0] acc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  alu_cmd_t        cmd_in, head;
  logic            fifo_full, fifo_empty, fire;
  logic [CW-1:0]   fifo_count;

  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_out_q, res_out_d;
  logic            res_equal_q, res_equal_d;
  logic            res_even_q, res_even_d;
  logic [W-1:0]    acc_q, acc_d;

  assign cmd_in = '{a: cmd_a, b: cmd_b, op: cmd_op, use_acc: cmd_use_acc};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(alu_cmd_t))
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && !fifo_full),
    .pop   (fire),
    .din   (cmd_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready reflects last edge's occupancy only; a same-cycle pop never frees a slot.
  assign cmd_ready = (fifo_count != FULL_CNT);
  assign fire      = !fifo_empty && (!res_valid_q || res_ready);

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    if (!fifo_empty) begin
      alu_a  = head.use_acc ? acc_q : head.a;
      alu_b  = head.b;
      alu_op = head.op;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    res_equal_d = res_equal_q;
    res_even_d  = res_even_q;
    acc_d       = acc_q;
    if (fire) begin
      res_valid_d = 1'b1;
      res_out_d   = alu_out;
      res_equal_d = alu_equal;
      res_even_d  = alu_even;
      acc_d       = alu_out;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_equal_q <= 1'b0;
      res_even_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_equal_q <= res_equal_d;
      res_even_q  <= res_even_d;
      acc_q       <= acc_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_equal = res_equal_q;
  assign res_even  = res_even_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU attached.
module tb_alu_issue_queue;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic       cmd_use_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_out;
  logic       alu_equal;
  logic       alu_even;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_out;
  logic       res_equal;
  logic       res_even;
  logic [3:0] acc;

  int checks = 0;
  int errors = 0;

  alu_issue_queue #(.DEPTH(4), .W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .cmd_use_acc (cmd_use_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .alu_equal   (alu_equal),
    .alu_even    (alu_even),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_out     (res_out),
    .res_equal   (res_equal),
    .res_even    (res_even),
    .acc         (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The external ALU: combinational, 4-bit wrap, EQUAL = (A==B), EVEN = ~OUT[0].
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end
  assign alu_equal = (alu_a == alu_b);
  assign alu_even  = ~alu_out[0];

  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] op, input logic ua, input logic rr);
    cmd_valid   = v;
    cmd_a       = a;
    cmd_b       = b;
    cmd_op      = op;
    cmd_use_acc = ua;
    res_ready   = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b0);
    #1;
    checkOutput("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    checkOutput("rst_res_valid", 8'(res_valid), 8'd0);
    checkOutput("rst_res_out",   8'(res_out),   8'd0);
    checkOutput("rst_acc",       8'(acc),       8'd0);
    checkOutput("rst_alu_a",     8'(alu_a),     8'd0);
    checkOutput("rst_alu_b",     8'(alu_b),     8'd0);
    tick();
    rst_n = 1'b1;

    $display("[TB] single ADD");
    applyStimulus(1'b1, 4'd3, 4'd4, OP_ADD, 1'b0, 1'b1);
    tick();
    checkOutput("add_valid_early", 8'(res_valid), 8'd0);
    checkOutput("add_issue_a",     8'(alu_a),     8'd3);
    checkOutput("add_issue_b",     8'(alu_b),     8'd4);
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b1);
    tick();
    checkOutput("add_valid", 8'(res_valid), 8'd1);
    checkOutput("add_out",   8'(res_out),   8'd7);
    checkOutput("add_equal", 8'(res_equal), 8'd0);
    checkOutput("add_even",  8'(res_even),  8'd0);
    checkOutput("add_acc",   8'(acc),       8'd7);
    checkOutput("empty_alu_a", 8'(alu_a),   8'd0);
    tick();
    checkOutput("add_drain_valid", 8'(res_valid), 8'd0);
    checkOutput("add_drain_hold",  8'(res_out),   8'd7);

    $display("[TB] wrap and flags");
    applyStimulus(1'b1, 4'd9, 4'd9, OP_ADD, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd5, 4'd5, OP_XOR, 1'b0, 1'b1);
    tick();
    checkOutput("wrap_out",   8'(res_out),   8'd2);
    checkOutput("wrap_equal", 8'(res_equal), 8'd1);
    checkOutput("wrap_even",  8'(res_even),  8'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b1);
    tick();
    checkOutput("xor_valid", 8'(res_valid), 8'd1);
    checkOutput("xor_out",   8'(res_out),   8'd0);
    checkOutput("xor_equal", 8'(res_equal), 8'd1);
    checkOutput("xor_even",  8'(res_even),  8'd1);
    tick();
    checkOutput("xor_drain", 8'(res_valid), 8'd0);

    $display("[TB] chaining");
    applyStimulus(1'b1, 4'd2, 4'd3, OP_ADD, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd15, 4'd4, OP_ADD, 1'b1, 1'b1);
    tick();
    checkOutput("chain1_out", 8'(res_out), 8'd5);
    checkOutput("chain1_acc", 8'(acc),     8'd5);
    applyStimulus(1'b1, 4'd0, 4'd8, OP_OR, 1'b1, 1'b1);
    tick();
    checkOutput("chain2_out", 8'(res_out), 8'd9);
    checkOutput("chain2_acc", 8'(acc),     8'd9);
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b1);
    tick();
    checkOutput("chain3_valid", 8'(res_valid), 8'd1);
    checkOutput("chain3_out",   8'(res_out),   8'd9);
    checkOutput("chain3_equal", 8'(res_equal), 8'd0);
    tick();
    checkOutput("chain_drain", 8'(res_valid), 8'd0);

    $display("[TB] full and back-pressure");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'(i), 4'd1, OP_ADD, 1'b0, 1'b0);
      tick();
    end
    checkOutput("full_ready",     8'(cmd_ready), 8'd0);
    checkOutput("full_res_valid", 8'(res_valid), 8'd1);
    checkOutput("full_res_out",   8'(res_out),   8'd1);
    applyStimulus(1'b1, 4'd7, 4'd1, OP_ADD, 1'b0, 1'b0);
    tick();
    checkOutput("stall_ready", 8'(cmd_ready), 8'd0);
    checkOutput("stall_out",   8'(res_out),   8'd1);
    checkOutput("stall_acc",   8'(acc),       8'd1);
    checkOutput("stall_head",  8'(alu_a),     8'd1);
    applyStimulus(1'b1, 4'd7, 4'd1, OP_ADD, 1'b0, 1'b1);
    tick();
    checkOutput("release_out",   8'(res_out),   8'd2);
    checkOutput("release_ready", 8'(cmd_ready), 8'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      checkOutput("drain_valid", 8'(res_valid), 8'd1);
      checkOutput("drain_out",   8'(res_out),   8'(i));
    end
    tick();
    checkOutput("full_refused_6th", 8'(res_valid), 8'd0);

    $display("[TB] simultaneous push/pop");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'(i), 4'd0, OP_ADD, 1'b0, 1'b0);
      tick();
    end
    checkOutput("pp_prefill_out", 8'(res_out), 8'd0);
    for (int j = 1; j <= 10; j++) begin
      applyStimulus(1'b1, 4'(j + 2), 4'd0, OP_ADD, 1'b0, 1'b1);
      tick();
      checkOutput("pp_out",   8'(res_out),   8'(j));
      checkOutput("pp_ready", 8'(cmd_ready), 8'd1);
    end
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b1);
    tick();
    checkOutput("pp_tail1", 8'(res_out), 8'd11);
    tick();
    checkOutput("pp_tail2", 8'(res_out), 8'd12);
    tick();
    checkOutput("pp_drain", 8'(res_valid), 8'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'(i), 4'd2, OP_ADD, 1'b0, 1'b0);
      tick();
    end
    checkOutput("pre_rst_valid", 8'(res_valid), 8'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 8'(res_valid), 8'd0);
    checkOutput("mid_rst_out",   8'(res_out),   8'd0);
    checkOutput("mid_rst_even",  8'(res_even),  8'd0);
    checkOutput("mid_rst_acc",   8'(acc),       8'd0);
    checkOutput("mid_rst_ready", 8'(cmd_ready), 8'd1);
    checkOutput("mid_rst_alu_b", 8'(alu_b),     8'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd1, 4'd1, OP_ADD, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD, 1'b0, 1'b1);
    tick();
    checkOutput("post_rst_valid", 8'(res_valid), 8'd1);
    checkOutput("post_rst_out",   8'(res_out),   8'd2);
    checkOutput("post_rst_acc",   8'(acc),       8'd2);
    tick();
    checkOutput("post_rst_drain", 8'(res_valid), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for the 4-bit `ALU` (ops ADD/AND/OR/XOR with EQUAL/EVEN flags). Accepts operation commands over a valid/ready handshake and buffers them in a 4-entry FIFO. Drives the head command onto the ALU's combinational inputs, then registers the ALU result and flags into a single output slot with its own valid/ready handshake. An accumulator lets a command take operand A from the previous retired result, so operations can be chained.

## Interface
Parameters:
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `W`, 4, operand/result width; must match ALU.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept.
- `cmd_a`  in  W  operand A; ignored when `cmd_use_acc`=1.
- `cmd_b`  in  W  operand B.
- `cmd_op`  in  2  00 ADD, 01 AND, 10 OR, 11 XOR.
- `cmd_use_acc`  in  1  take A from accumulator at issue time.
- `alu_a`, `alu_b`  out  W  to ALU A/B.
- `alu_op`  out  2  to ALU op.
- `alu_out`  in  W  from ALU OUT.
- `alu_equal`, `alu_even`  in  1  from ALU EQUAL/EVEN.
- `res_valid`  out  1  result slot full.
- `res_ready`  in  1  consumer takes result.
- `res_out`  out  W  registered result.
- `res_equal`, `res_even`  out  1  registered flags.
- `acc`  out  W  accumulator value.

## Operation
- Push: `cmd_valid && cmd_ready` stores {a,b,op,use_acc} at the tail. `cmd_ready = (count != DEPTH)`, registered-count based. There is no pass-through when full, even if a pop happens in the same cycle.
- Issue: when the FIFO is non-empty, drive the head combinationally:
  - `alu_a = use_acc ? acc : a`; `alu_b = b`; `alu_op = op`.
  - When the FIFO is empty, drive all ALU inputs to 0.
- Retire (capture): `fire = !empty && (!res_valid || res_ready)`. On `fire`:
  - pop the head;
  - load `res_out/res_equal/res_even` from the ALU;
  - set `res_valid=1`;
  - set `acc <= alu_out`.
- Drain without a new fire (`res_valid && res_ready && empty`): clear `res_valid`; hold `res_*` data.
- Back-pressure: `res_valid && !res_ready` stalls retire. The head stays driven and all `res_*` and `acc` are held stable.
- Arithmetic is W-bit modulo, as in the ALU (ADD wraps and there is no carry out). `acc` is updated only on `fire`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. Pointers wrap modulo DEPTH.

## Timing
- Reset values (async assert, applied immediately): `count=0`, both pointers 0, `res_valid=0`, `res_out=0`, `res_equal=0`, `res_even=0`, `acc=0`. Hence `cmd_ready=1` and ALU inputs are 0.
- Reset asserted mid-operation discards all queued commands and any pending result.
- Latency with an empty FIFO and an empty slot:
  - command accepted at edge k;
  - its result is captured at edge k+1;
  - `res_valid` is high from edge k+1.
- Throughput: one command per cycle when `res_ready` is held at 1.
- A chained `use_acc` command issued directly after its predecessor sees the predecessor's result, because `acc` updates at the same edge as the pop. No bubble is needed.
- Full: with `count=DEPTH`, `cmd_ready=0` for that whole cycle.
- Empty: no fire. `res_valid` falls on the first edge where `res_ready=1`.

## Structure
- Shared package `alu_pkg`:
  - op encoding constants `OP_ADD=2'b00`, `OP_AND=2'b01`, `OP_OR=2'b10`, `OP_XOR=2'b11`;
  - width constant `ALU_W=4`;
  - `alu_cmd_t` struct {a, b, op, use_acc}.
- One sub-module: `cmd_fifo`, a generic DEPTH-entry synchronous FIFO (push/pop/full/empty/count, async active-low reset).
- The top level holds the issue mux, the result slot and the accumulator. It instantiates the FIFO only, not the ALU.

## Test plan
- Single ADD: push a=3, b=4, op=00 with `res_ready=1` → `res_valid` rises one edge after acceptance; `res_out`=7, `res_equal`=0, `res_even`=0; `acc`=7.
- Wrap and flags: push ADD 9+9, then XOR 5^5 → results 2 (even=1, equal=1), then 0 (even=1, equal=1).
- Chaining: push ADD 2+3, then ADD use_acc b=4, then OR use_acc b=8 → results 5, 9, 9. Back-to-back issue with no bubbles.
- Full/back-pressure: hold `res_ready=0` and push 5 commands → 1 retires to the slot and 4 fill the FIFO. `cmd_ready` is 0 after the 5th acceptance and the 6th push is refused. Release `res_ready` → results drain in order, one per cycle.
- Simultaneous push/pop at `count`=2 over 10 cycles → count stays 2, pointers wrap, results stay in order.
- Reset mid-stream: assert `rst_n`=0 with 3 queued and `res_valid`=1 → all outputs go to reset values immediately; after release, a new ADD 1+1 returns 2.
